// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. One full-adder cell processes a bit pair per clock,
// LSB first, with the carry recirculated through a flip-flop. A start handshake
// loads A, B and C_in; a one-cycle done pulse marks a new registered {C_out, S}.

// Single-bit full-adder cell driven by the serial stage.
module b1_adder (
  input  logic X,
  input  logic Y,
  input  logic C_in,
  output logic Z,
  output logic C_out
);

  assign Z     = X ^ Y ^ C_in;
  assign C_out = (X & Y) | (X & C_in) | (Y & C_in);

endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    StIdle  = 3'b001,
    StShift = 3'b010,
    StDone  = 3'b100
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic             cy;
  logic [CntW-1:0]  cnt;
  logic             accept;
  logic             last;
  logic             fa_z, fa_cout;

  assign last = (cnt == CntW'(WIDTH - 1));

  b1_adder u_fa (
    .X     (a_sh[0]),
    .Y     (b_sh[0]),
    .C_in  (cy),
    .Z     (fa_z),
    .C_out (fa_cout)
  );

  // Next-state decode; start is only honoured in IDLE or DONE.
  always_comb begin
    state_d = StIdle;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          accept  = 1'b1;
        end
      end
      StShift: begin
        state_d = last ? StDone : StShift;
      end
      StDone: begin
        if (start) begin
          state_d = StShift;
          accept  = 1'b1;
        end
      end
      default: state_d = StIdle;  // illegal encodings fall back to IDLE
    endcase
  end

  // State register; busy/done are registered from the next state so they never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == StShift);
      done    <= (state_d == StDone);
    end
  end

  // Operand load, per-bit shift and carry recirculation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      a_sh <= A;
      b_sh <= B;
      cy   <= C_in;
      cnt  <= '0;
    end else if (state_q == StShift) begin
      a_sh <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh <= {1'b0, b_sh[WIDTH-1:1]};
      s_sh <= {fa_z, s_sh[WIDTH-1:1]};
      cy   <= fa_cout;
      cnt  <= cnt + 1'b1;
    end
  end

  // Result registers update only on the last shift edge and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S     <= '0;
      C_out <= 1'b0;
    end else if ((state_q == StShift) && last) begin
      S     <= {fa_z, s_sh[WIDTH-1:1]};
      C_out <= fa_cout;
    end
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around the team's `b1_adder` full-adder cell (X, Y, C_in → Z, C_out). It is the sequential stage that drives that cell. It loads two operands and a carry-in on a start handshake, then feeds one bit pair per clock, LSB first, into a single `b1_adder` instance, recirculating the carry through a flip-flop. It returns the WIDTH-bit sum and final carry with a one-cycle done pulse. It is the area-minimal alternative to a ripple chain of WIDTH `b1_adder` cells.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request. Sampled only in IDLE or DONE.
- `A`  in  WIDTH: operand A, captured when start is accepted.
- `B`  in  WIDTH: operand B, captured when start is accepted.
- `C_in`  in  1: carry-in, captured when start is accepted.
- `busy`  out  1: high while in SHIFT.
- `done`  out  1: one-cycle pulse; S and C_out are valid from this cycle onward.
- `S`  out  WIDTH: registered sum.
- `C_out`  out  1: registered final carry.

## Operation
- Datapath registers:
  - `a_sh` and `b_sh`: WIDTH-bit right-shift registers.
  - `s_sh`: WIDTH-bit right-shift register.
  - `cy`: 1-bit carry flip-flop.
  - `cnt`: counts 0..WIDTH-1, $clog2(WIDTH) bits.
  - `S` and `C_out`: output registers.
- Single `b1_adder` instance with X=`a_sh[0]`, Y=`b_sh[0]`, C_in=`cy`; its outputs are Z and C_out.
- IDLE:
  - busy=0, done=0.
  - If start=1: `a_sh`←A, `b_sh`←B, `cy`←C_in, `cnt`←0, go to SHIFT.
- SHIFT: busy=1. At each rising edge:
  - `s_sh`←{Z, `s_sh`[WIDTH-1:1]}.
  - `a_sh` and `b_sh` shift right by one, filling with 0.
  - `cy`←adder carry out.
  - `cnt`←`cnt`+1.
- SHIFT exit: at the edge where `cnt`=WIDTH-1, the last bit is processed and the FSM goes to DONE. On that same edge, S←{Z, `s_sh`[WIDTH-1:1]} (the final shifted value) and C_out←adder carry out.
- DONE:
  - done=1, busy=0.
  - If start=1, accept new operands exactly as in IDLE and go to SHIFT (back-to-back operation).
  - Otherwise go to IDLE.
- start in SHIFT is ignored. It is not queued.
- S and C_out hold their values until the next DONE entry. A new operation does not clear them.
- Arithmetic: {C_out, S} = A + B + C_in, modulo 2^(WIDTH+1). No overflow flag.
- Outputs S, C_out, busy and done come directly from registers. There are no combinational paths from inputs to outputs.

## Timing
- Reset values while `rst`=1, applied asynchronously:
  - state=IDLE; busy=0, done=0, S=0, C_out=0.
  - `a_sh`, `b_sh`, `s_sh`, `cy`, `cnt` all 0.
- Reset mid-operation aborts immediately. No done pulse is produced for the aborted operation, and S and C_out read 0.
- Latency: start is sampled at edge k. busy is high from edge k to edge k+WIDTH. done is high from edge k+WIDTH to edge k+WIDTH+1.
- Throughput: one result every WIDTH+1 cycles with start held high continuously.
- busy and done are never high in the same cycle.
- The FSM is one-hot or binary (implementer's choice) with states IDLE, SHIFT and DONE only. Unreachable encodings recover to IDLE.

## Test plan
- Reset, then WIDTH=8, A=0x3C, B=0x0F, C_in=0, start pulse → busy high 8 cycles; done pulse on the 9th edge after start; S=0x4B, C_out=0.
- A=0xFF, B=0x01, C_in=0 → S=0x00, C_out=1. Then A=0xA5, B=0x5A, C_in=1 → S=0x00, C_out=1.
- Hold start high with A=0x01, B=0x01, C_in=0 → done pulses every 9 cycles, S=0x02 each time. Change the operands to A=0x80, B=0x80 during SHIFT; the sum is unaffected until the next acceptance, which yields S=0x00, C_out=1.
- Start A=0x10, B=0x20, then pulse start with A=0xFF, B=0xFF at cycle 3 of SHIFT → ignored; result S=0x30, C_out=0; done occurs exactly once.
- Assert rst at cycle 4 of SHIFT for 1 cycle → busy=0, done never pulses, S=0x00, C_out=0. A subsequent start with A=0x7F, B=0x01, C_in=1 → S=0x81, C_out=0.
- Exhaustive check for WIDTH=4 over all A, B, C_in (512 cases): {C_out, S} equals A+B+C_in, and done-to-start spacing is 5 cycles.
